// File: rtl/hps_ext_arbiter.sv
// hps_ext_arbiter: owns the HPS EXT_BUS command channel and hands each command to the
// lowest-indexed client whose inclusive command range contains it.
module hps_ext_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter logic [32*NUM_CLIENTS-1:0] CMD_RANGES = {16'h00FF, 16'h00F2, 16'h00F1, 16'h00F0}
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    inout  wire  [35:0]               EXT_BUS,
    output logic [NUM_CLIENTS-1:0]    cli_sel,
    output logic [15:0]               cli_cmd,
    output logic [4:0]                cli_idx,
    output logic                      cli_wr,
    output logic [15:0]               cli_din,
    input  logic [16*NUM_CLIENTS-1:0] cli_dout,
    output logic                      cmd_active,
    output logic [7:0]                unclaimed_cnt
);
    typedef enum logic [1:0] {IDLE, ACTIVE, UNCLAIMED} state_t;

    state_t                  r_state, w_state_nxt;
    logic [15:0]             r_dout, w_dout_nxt;
    logic                    r_den, w_den_nxt;
    logic [NUM_CLIENTS-1:0]  r_sel, w_sel_nxt;
    logic [15:0]             r_cmd, w_cmd_nxt;
    logic [4:0]              r_idx, w_idx_nxt;
    logic                    r_wr, w_wr_nxt;
    logic [15:0]             r_din, w_din_nxt;
    logic [7:0]              r_uncl, w_uncl_nxt;

    logic                    w_en, w_stb, w_unused;
    logic [15:0]             w_io_din;
    logic [NUM_CLIENTS-1:0]  w_match, w_first;
    logic [15:0]             w_acc [NUM_CLIENTS+1];

    // Only io_dout and dout_en are driven; every other bit belongs to the HPS side.
    assign EXT_BUS  = {3'bzzz, r_den, 16'hzzzz, r_dout};
    assign w_io_din = EXT_BUS[31:16];
    assign w_stb    = EXT_BUS[33];
    assign w_en     = EXT_BUS[34];
    assign w_unused = EXT_BUS[35];

    assign w_acc[0] = '0;
    genvar g;
    generate
        for (g = 0; g < NUM_CLIENTS; g++) begin : g_client
            assign w_match[g] = (w_io_din >= CMD_RANGES[32*g +: 16]) &&
                                (w_io_din <= CMD_RANGES[32*g+16 +: 16]);
            assign w_acc[g+1] = w_acc[g] | ({16{r_sel[g]}} & cli_dout[16*g +: 16]);
        end
    endgenerate

    // Isolate the lowest set bit so overlapping ranges go to the lowest client index.
    assign w_first = w_match & (-w_match);

    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_den_nxt   = r_den;
        w_sel_nxt   = r_sel;
        w_cmd_nxt   = r_cmd;
        w_idx_nxt   = r_idx;
        w_wr_nxt    = 1'b0;
        w_din_nxt   = r_din;
        w_uncl_nxt  = r_uncl;
        if (!w_en) begin
            w_state_nxt = IDLE;
            w_dout_nxt  = '0;
            w_den_nxt   = 1'b0;
            w_sel_nxt   = '0;
            w_idx_nxt   = '0;
        end else if (w_stb && r_state == IDLE) begin
            w_cmd_nxt   = w_io_din;
            w_idx_nxt   = 5'd1;
            w_dout_nxt  = '0;
            w_sel_nxt   = w_first;
            w_den_nxt   = |w_match;
            w_state_nxt = |w_match ? ACTIVE : UNCLAIMED;
            w_uncl_nxt  = (|w_match || &r_uncl) ? r_uncl : r_uncl + 8'd1;
        end else if (w_stb && r_state == ACTIVE) begin
            w_din_nxt   = w_io_din;
            w_wr_nxt    = 1'b1;
            w_dout_nxt  = w_acc[NUM_CLIENTS];
            w_idx_nxt   = &r_idx ? r_idx : r_idx + 5'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dout  <= '0;
            r_den   <= 1'b0;
            r_sel   <= '0;
            r_cmd   <= '0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_din   <= '0;
            r_uncl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_dout_nxt;
            r_den   <= w_den_nxt;
            r_sel   <= w_sel_nxt;
            r_cmd   <= w_cmd_nxt;
            r_idx   <= w_idx_nxt;
            r_wr    <= w_wr_nxt;
            r_din   <= w_din_nxt;
            r_uncl  <= w_uncl_nxt;
        end
    end

    assign cli_sel       = r_sel;
    assign cli_cmd       = r_cmd;
    assign cli_idx       = r_idx;
    assign cli_wr        = r_wr;
    assign cli_din       = r_din;
    assign cmd_active    = (r_state == ACTIVE);
    assign unclaimed_cnt = r_uncl;
endmodule

// File: doc/hps_ext_arbiter.md
Name: hps_ext_arbiter

Overview:
Owns the 36-bit HPS EXT_BUS command channel and shares it among NUM_CLIENTS command handlers, such as the vcount/init handler and future audio or blit handlers. It latches the command word, decodes it against each client's command range, and counts data words. It forwards write words and strobes to the owning client, registers that client's read word onto the bus, and drives the dout_en claim. Clients no longer touch EXT_BUS directly; each sees a simple select/strobe/index interface.

Parameters:
NUM_CLIENTS, 2, number of handler clients (1..8)
CMD_RANGES, {16'h00FF,16'h00F2,16'h00F1,16'h00F0}, packed per client i: bits [32i+15:32i]=min cmd, [32i+31:32i+16]=max cmd, inclusive

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
EXT_BUS  inout  36  [15:0] io_dout (driven), [31:16] io_din, [32] dout_en (driven), [33] io_strobe, [34] io_enable, [35] unused/not driven
cli_sel  out  NUM_CLIENTS  one-hot owner of the current transaction; 0 when none
cli_cmd  out  16  latched command word
cli_idx  out  5  data word index for the current or next strobe (1..31)
cli_wr  out  1  one-cycle pulse: data word io_din valid on cli_din at index cli_idx
cli_din  out  16  registered io_din
cli_dout  in  16*NUM_CLIENTS  client i read word for index cli_idx, at [16i+15:16i]; combinational from client registers
cmd_active  out  1  high while in ACTIVE state
unclaimed_cnt  out  8  saturating count of commands no client claimed

Behaviour:
- Async reset (reset_n=0): state=IDLE. io_dout=0, dout_en=0, cli_sel=0, cli_cmd=0, cli_idx=0, cli_wr=0, cli_din=0, cmd_active=0, unclaimed_cnt=0.
- States: IDLE, ACTIVE, UNCLAIMED.
- Any state, io_enable=0 (highest priority after reset):
  - next state IDLE; dout_en, io_dout, cli_sel, cli_idx, cli_wr cleared the next cycle.
  - cli_cmd holds its value.
  - This is the abort path mid-transaction; no further cli_wr may issue.
- IDLE, io_enable=1 and io_strobe=1 (command word):
  - cli_cmd<=io_din; cli_idx<=1; io_dout<=0.
  - Match: the lowest client i with min_i<=io_din<=max_i (unsigned 16-bit compare; overlap resolved by lowest index). On match: cli_sel<=1<<i, dout_en<=1, go ACTIVE.
  - No match: cli_sel<=0, dout_en<=0, unclaimed_cnt+1 saturating at 255, go UNCLAIMED.
- ACTIVE, io_strobe=1 (data word k=cli_idx):
  - cli_din<=io_din; cli_wr<=1 for exactly one cycle; io_dout<=cli_dout of the selected client, sampled the same cycle.
  - cli_idx<=cli_idx+1, saturating at 31. At 31 further strobes keep reusing index 31.
- ACTIVE, io_strobe=0: cli_wr<=0; all other outputs hold.
- UNCLAIMED: strobes ignored; io_dout stays 0, dout_en stays 0, cli_wr never asserted, until io_enable=0.
- Latency:
  - cli_wr and cli_din appear 1 cycle after the strobe edge.
  - Read data is registered on the strobe cycle and is visible on io_dout from the next cycle, for the HPS to read on its next access.
  - Clients must present cli_dout for index cli_idx whenever cli_sel is set.
- Strobe and enable falling together: the enable drop wins; the strobe is ignored.
- Back-to-back strobes on consecutive cycles are supported; each produces its own cli_wr pulse.
- The unclaimed_cnt counter only clears on reset.

Test Plan:
1. Reset released, enable=1, strobe cmd 16'h00F0 -> next cycle cli_sel=01, dout_en=1, cli_cmd=F0, cli_idx=1, io_dout=0, cmd_active=1.
2. After scenario 1, client0 drives cli_dout=16'h0123 at idx1, strobe with io_din=16'h0001 -> cli_wr pulse 1 cycle, cli_din=0001, io_dout=0123, cli_idx=2.
3. Cmd 16'h0010 (no range) then 3 strobes -> dout_en=0, io_dout=0, no cli_wr, unclaimed_cnt=1. Repeat 300 times -> saturates at 255.
4. Overlapping ranges client0=F0..F8 and client1=F4..FF, cmd F5 -> cli_sel=01. Cmd F9 -> cli_sel=10.
5. 40 data strobes in one transaction -> cli_idx sequence 1..31, then stays 31. 40 cli_wr pulses total.
6. io_enable dropped mid-transaction at idx 3, strobe on the same cycle -> no cli_wr. Next cycle IDLE with dout_en=0, cli_sel=0, cli_idx=0. reset_n pulsed low asynchronously mid-ACTIVE -> all outputs 0 immediately.
